// File: rtl/qdr_frame_ring.sv
// qdr_frame_ring
// Per-port circular frame buffer between a 128-bit ingress frame stream and
// a QDR-II+ 144-bit read/write interface. Frames are written speculatively
// and committed only when complete and good; committed frames are read back
// on request from the forwarding fabric. Overflow drops whole frames; the
// ingress side is never backpressured.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_last/in_bytes/in_drop/in_data   ingress frame stream
//   ram_wr_en/ram_wr_addr/ram_wr_data           SRAM write port
//   ram_rd_en/ram_rd_addr                       SRAM read request
//   ram_rd_valid/ram_rd_data                    SRAM read return (in order)
//   frame_pending         at least one committed frame available
//   forward_en            fabric grant for the next frame
//   frame_valid/frame_last/frame_bytes/frame_data  egress word stream
//   drop_count            saturating count of dropped frames
module qdr_frame_ring #(
  parameter int                   ADDR_BITS      = 18,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR      = '0,
  parameter int                   DEPTH_BITS     = 12,
  parameter int                   LEN_FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [4:0]           in_bytes,
  input  logic                 in_drop,
  input  logic [127:0]         in_data,
  output logic                 ram_wr_en,
  output logic [ADDR_BITS-1:0] ram_wr_addr,
  output logic [143:0]         ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_rd_addr,
  input  logic                 ram_rd_valid,
  input  logic [143:0]         ram_rd_data,
  output logic                 frame_pending,
  input  logic                 forward_en,
  output logic                 frame_valid,
  output logic                 frame_last,
  output logic [4:0]           frame_bytes,
  output logic [127:0]         frame_data,
  output logic [15:0]          drop_count
);

  localparam int PW  = DEPTH_BITS + 1;
  localparam int LFW = $clog2(LEN_FIFO_DEPTH);
  localparam int CW  = LFW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  // Write side
  logic                 r_wr_en;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [143:0]         r_wr_data;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_commit_ptr;
  logic [PW-1:0]        r_wcnt;
  logic                 r_discard;
  logic [15:0]          r_drop_count;

  // Length FIFO
  logic [PW-1:0]        r_lf_mem [LEN_FIFO_DEPTH];
  logic [LFW-1:0]       r_lf_wp;
  logic [LFW-1:0]       r_lf_rp;
  logic [CW-1:0]        r_lf_cnt;

  // Read side
  state_t               r_state;
  logic                 r_rd_en;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_remaining;
  logic [PW-1:0]        r_outstanding;
  logic [PW-1:0]        r_free_ptr;
  logic                 r_fvalid;
  logic                 r_flast;
  logic [4:0]           r_fbytes;
  logic [127:0]         r_fdata;

  logic                 w_full;
  logic                 w_lf_full;
  logic                 w_pending;
  logic                 w_wr;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_ret;
  logic [PW-1:0]        w_lf_head;
  logic                 w_unused_pad;

  function automatic logic [ADDR_BITS-1:0] f_addr(input logic [PW-1:0] p);
    logic [ADDR_BITS-1:0] a;
    a = '0;
    a[DEPTH_BITS-1:0] = p[DEPTH_BITS-1:0];
    return BASE_ADDR | a;
  endfunction

  assign w_full       = ((r_wr_ptr - r_free_ptr) == CAP);
  assign w_lf_full    = (r_lf_cnt == CW'(LEN_FIFO_DEPTH));
  assign w_pending    = (r_lf_cnt != '0);
  assign w_lf_head    = r_lf_mem[r_lf_rp];
  assign w_pop        = (r_state == S_IDLE) && w_pending && forward_en;
  // Returns with nothing outstanding (e.g. reads issued before a reset) are ignored.
  assign w_rd_ret     = ram_rd_valid && (r_outstanding != '0);
  assign w_unused_pad = ^ram_rd_data[137:128];

  always_comb begin
    w_wr   = 1'b0;
    w_drop = 1'b0;
    w_push = 1'b0;
    if (in_valid && !r_discard) begin
      if (w_full) begin
        w_drop = 1'b1;
      end else if (in_last && (in_drop || w_lf_full)) begin
        w_drop = 1'b1;
      end else begin
        w_wr   = 1'b1;
        w_push = in_last;
      end
    end
  end

  // Write path: speculative writes, commit on good last word, rollback on drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_wcnt       <= '0;
      r_discard    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= f_addr(r_wr_ptr);
        r_wr_data <= {in_last, in_bytes, 10'b0, in_data};
        r_wr_ptr  <= r_wr_ptr + ONE;
        if (in_last) begin
          r_commit_ptr <= r_wr_ptr + ONE;
          r_wcnt       <= '0;
        end else begin
          r_wcnt <= r_wcnt + ONE;
        end
      end
      if (w_drop) begin
        r_wr_ptr  <= r_commit_ptr;
        r_wcnt    <= '0;
        r_discard <= ~in_last;
        if (r_drop_count != '1)
          r_drop_count <= r_drop_count + 16'd1;
      end
      if (in_valid && r_discard && in_last)
        r_discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_lf_mem[r_lf_wp] <= r_wcnt + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lf_wp  <= '0;
      r_lf_rp  <= '0;
      r_lf_cnt <= '0;
    end else begin
      if (w_push)
        r_lf_wp <= r_lf_wp + LFW'(1);
      if (w_pop)
        r_lf_rp <= r_lf_rp + LFW'(1);
      r_lf_cnt <= r_lf_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Reader FSM. The first read is issued directly from IDLE so the read
  // burst starts the cycle after the grant and runs without gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_en <= 1'b0;
          if (w_pop) begin
            r_rd_en     <= 1'b1;
            r_rd_addr   <= f_addr(r_rd_ptr);
            r_rd_ptr    <= r_rd_ptr + ONE;
            r_remaining <= w_lf_head - ONE;
            r_state     <= (w_lf_head == ONE) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rd_en     <= 1'b1;
          r_rd_addr   <= f_addr(r_rd_ptr);
          r_rd_ptr    <= r_rd_ptr + ONE;
          r_remaining <= r_remaining - ONE;
          if (r_remaining == ONE)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_rd_en <= 1'b0;
          // The final read is still on the bus during the first DRAIN cycle
          // and not yet counted in r_outstanding.
          if (!r_rd_en && (r_outstanding == '0))
            r_state <= S_IDLE;
        end
        default: begin
          r_rd_en <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({r_rd_en, w_rd_ret})
        2'b10:   r_outstanding <= r_outstanding + ONE;
        2'b01:   r_outstanding <= r_outstanding - ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Output path; space is released only when data comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fvalid   <= 1'b0;
      r_flast    <= 1'b0;
      r_fbytes   <= '0;
      r_fdata    <= '0;
      r_free_ptr <= '0;
    end else begin
      r_fvalid <= w_rd_ret;
      r_flast  <= w_rd_ret & ram_rd_data[143];
      if (w_rd_ret) begin
        r_fbytes   <= ram_rd_data[142:138];
        r_fdata    <= ram_rd_data[127:0];
        r_free_ptr <= r_free_ptr + ONE;
      end
    end
  end

  assign ram_wr_en     = r_wr_en;
  assign ram_wr_addr   = r_wr_addr;
  assign ram_wr_data   = r_wr_data;
  assign ram_rd_en     = r_rd_en;
  assign ram_rd_addr   = r_rd_addr;
  assign frame_pending = w_pending;
  assign frame_valid   = r_fvalid;
  assign frame_last    = r_flast;
  assign frame_bytes   = r_fbytes;
  assign frame_data    = r_fdata;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_qdr_frame_ring.sv
// Testbench for qdr_frame_ring: table-driven write-path vectors plus
// hand-written read, wrap, commit/pop overlap, FIFO-full and reset sequences.
module tb_qdr_frame_ring;

  localparam int             AB   = 18;
  localparam logic [AB-1:0]  BASE = 18'h000A0;
  localparam int             DB   = 4;
  localparam int             LFD  = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_last;
  logic [4:0]    in_bytes;
  logic          in_drop;
  logic [127:0]  in_data;
  logic          ram_wr_en;
  logic [AB-1:0] ram_wr_addr;
  logic [143:0]  ram_wr_data;
  logic          ram_rd_en;
  logic [AB-1:0] ram_rd_addr;
  logic          ram_rd_valid;
  logic [143:0]  ram_rd_data;
  logic          frame_pending;
  logic          forward_en;
  logic          frame_valid;
  logic          frame_last;
  logic [4:0]    frame_bytes;
  logic [127:0]  frame_data;
  logic [15:0]   drop_count;

  qdr_frame_ring #(
    .ADDR_BITS(AB),
    .BASE_ADDR(BASE),
    .DEPTH_BITS(DB),
    .LEN_FIFO_DEPTH(LFD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_bytes(in_bytes),
    .in_drop(in_drop), .in_data(in_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .frame_pending(frame_pending), .forward_en(forward_en),
    .frame_valid(frame_valid), .frame_last(frame_last),
    .frame_bytes(frame_bytes), .frame_data(frame_data),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: fixed 3-cycle read latency, in order.
  logic [143:0]  mem [256];
  logic [2:0]    p_en = '0;
  logic [AB-1:0] p_addr [3];
  logic          stray = 1'b0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr[7:0]] <= ram_wr_data;
    p_en      <= {p_en[1:0], ram_rd_en};
    p_addr[0] <= ram_rd_addr;
    p_addr[1] <= p_addr[0];
    p_addr[2] <= p_addr[1];
  end
  assign ram_rd_valid = p_en[2] | stray;
  assign ram_rd_data  = mem[p_addr[2][7:0]];

  // Monitor
  logic [AB-1:0] wr_addr_q [$];
  logic [AB-1:0] rd_addr_q [$];
  int            rd_cyc_q  [$];
  logic [133:0]  out_q     [$];
  always @(negedge clk) begin
    if (ram_wr_en) wr_addr_q.push_back(ram_wr_addr);
    if (ram_rd_en) begin
      rd_addr_q.push_back(ram_rd_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (frame_valid) out_q.push_back({frame_last, frame_bytes, frame_data});
  end

  logic [AB-1:0] exp_addrs [$];
  logic [133:0]  exp_words [$];

  typedef struct {
    bit         rst;
    bit         v;
    bit         last;
    logic [4:0] bytes;
    bit         drop;
    logic [7:0] tag;
    bit         we;
    logic [3:0] off;
    logic [15:0] drops;
    bit         pend;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(bit rst, bit v, bit last, logic [4:0] bytes, bit drop,
                              logic [7:0] tag, bit we, logic [3:0] off,
                              logic [15:0] drops, bit pend);
    vec_t t;
    t.rst = rst; t.v = v; t.last = last; t.bytes = bytes; t.drop = drop;
    t.tag = tag; t.we = we; t.off = off; t.drops = drops; t.pend = pend;
    tbl.push_back(t);
  endfunction

  task automatic drive(bit v, bit last, logic [4:0] bytes, bit drop, logic [7:0] tag);
    in_valid = v;
    in_last  = last;
    in_bytes = bytes;
    in_drop  = drop;
    in_data  = {16{tag}};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 5'd0, 0, 8'h00);
    forward_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(bit last, logic [4:0] bytes, bit drop, logic [7:0] tag);
    drive(1, last, bytes, drop, tag);
    @(negedge clk);
  endtask

  task automatic send_frame(int n, logic [7:0] tb, logic [4:0] lb);
    for (int i = 0; i < n; i++)
      send_word(i == n - 1, (i == n - 1) ? lb : 5'd16, 0, 8'(tb + 8'(i)));
    drive(0, 0, 5'd0, 0, 8'h00);
  endtask

  task automatic exp_frame(int n, logic [7:0] tb, logic [4:0] lb, int off);
    for (int i = 0; i < n; i++) begin
      exp_addrs.push_back(BASE | AB'((off + i) % 16));
      exp_words.push_back({1'(i == n - 1), (i == n - 1) ? lb : 5'd16, {16{8'(tb + 8'(i))}}});
    end
  endtask

  task automatic clear_q();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    out_q.delete();
  endtask

  task automatic fwd_start(input string nm, output int c);
    chk({nm, "_pend"}, 144'(frame_pending), 144'(1));
    clear_q();
    forward_en = 1'b1;
    c = cyc;
    @(negedge clk);
    forward_en = 1'b0;
  endtask

  task automatic collect_check(input string nm, input int c);
    int t;
    t = 0;
    while (out_q.size() < exp_words.size() && t < 80) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk({nm, "_nreads"}, 144'(rd_addr_q.size()), 144'(exp_addrs.size()));
    chk({nm, "_nwords"}, 144'(out_q.size()), 144'(exp_words.size()));
    for (int i = 0; i < exp_addrs.size() && i < rd_addr_q.size(); i++) begin
      chk($sformatf("%s_rdaddr%0d", nm, i), 144'(rd_addr_q[i]), 144'(exp_addrs[i]));
      chk($sformatf("%s_rdcyc%0d", nm, i), 144'(rd_cyc_q[i]), 144'(c + 1 + i));
    end
    for (int i = 0; i < exp_words.size() && i < out_q.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 144'(out_q[i]), 144'(exp_words[i]));
    exp_addrs.delete();
    exp_words.delete();
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_wr_en"},   144'(ram_wr_en),     '0);
    chk({nm, "_wr_addr"}, 144'(ram_wr_addr),   '0);
    chk({nm, "_wr_data"}, ram_wr_data,         '0);
    chk({nm, "_rd_en"},   144'(ram_rd_en),     '0);
    chk({nm, "_rd_addr"}, 144'(ram_rd_addr),   '0);
    chk({nm, "_pend"},    144'(frame_pending), '0);
    chk({nm, "_fvalid"},  144'(frame_valid),   '0);
    chk({nm, "_flast"},   144'(frame_last),    '0);
    chk({nm, "_fbytes"},  144'(frame_bytes),   '0);
    chk({nm, "_fdata"},   144'(frame_data),    '0);
    chk({nm, "_drops"},   144'(drop_count),    '0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    forward_en = 1'b0;
    drive(0, 0, 5'd0, 0, 8'h00);
    @(negedge clk);
    check_reset_vals("por");

    // Oversized frame: words 0..15 fill the region, word 16 finds it full.
    for (int w = 0; w < 20; w++)
      add(w == 0, 1, w == 19, 5'd16, 0, 8'(8'h30 + 8'(w)),
          w < 16, 4'(w), (w < 16) ? 16'd0 : 16'd1, 0);
    add(0, 1, 0, 5'd16, 0, 8'h50, 1, 4'd0, 16'd1, 0);
    add(0, 1, 1, 5'd16, 0, 8'h51, 1, 4'd1, 16'd1, 1);
    // Bad frame (in_drop on last) then a good frame at offset 0.
    add(1, 1, 0, 5'd16, 0, 8'h60, 1, 4'd0, 16'd0, 0);
    add(0, 1, 0, 5'd16, 0, 8'h61, 1, 4'd1, 16'd0, 0);
    add(0, 1, 1, 5'd16, 1, 8'h62, 0, 4'd0, 16'd1, 0);
    add(0, 1, 0, 5'd16, 0, 8'h70, 1, 4'd0, 16'd1, 0);
    add(0, 1, 1, 5'd9,  0, 8'h71, 1, 4'd1, 16'd1, 1);
    add(0, 0, 0, 5'd0,  0, 8'h00, 0, 4'd0, 16'd1, 1);
    // 4-word frame, last word carries 5 bytes.
    add(0, 1, 0, 5'd16, 0, 8'h11, 1, 4'd2, 16'd1, 1);
    add(0, 1, 0, 5'd16, 0, 8'h12, 1, 4'd3, 16'd1, 1);
    add(0, 1, 0, 5'd16, 0, 8'h13, 1, 4'd4, 16'd1, 1);
    add(0, 1, 1, 5'd5,  0, 8'h14, 1, 4'd5, 16'd1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v, tbl[i].last, tbl[i].bytes, tbl[i].drop, tbl[i].tag);
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", i), 144'(ram_wr_en), 144'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_wr_addr", i), 144'(ram_wr_addr), 144'(BASE | AB'(tbl[i].off)));
        chk($sformatf("v%0d_wr_data", i), ram_wr_data,
            {tbl[i].last, tbl[i].bytes, 10'b0, {16{tbl[i].tag}}});
      end
      chk($sformatf("v%0d_drops", i), 144'(drop_count), 144'(tbl[i].drops));
      chk($sformatf("v%0d_pend", i), 144'(frame_pending), 144'(tbl[i].pend));
    end
    drive(0, 0, 5'd0, 0, 8'h00);

    // Exactly the two committed frames come out, in order.
    exp_frame(2, 8'h70, 5'd9, 0);
    fwd_start("rdA", c);
    collect_check("rdA", c);
    exp_frame(4, 8'h11, 5'd5, 2);
    fwd_start("rdB", c);
    collect_check("rdB", c);
    chk("rd_done_pend", 144'(frame_pending), '0);

    // Wrap-around.
    do_reset();
    send_frame(5, 8'hA0, 5'd7);
    send_frame(5, 8'hB0, 5'd8);
    send_frame(5, 8'hC0, 5'd9);
    exp_frame(5, 8'hA0, 5'd7, 0);
    fwd_start("wrA", c);
    collect_check("wrA", c);
    exp_frame(5, 8'hB0, 5'd8, 5);
    fwd_start("wrB", c);
    collect_check("wrB", c);
    exp_frame(5, 8'hC0, 5'd9, 10);
    fwd_start("wrC", c);
    collect_check("wrC", c);
    wr_addr_q.delete();
    send_frame(5, 8'hD0, 5'd3);
    repeat (2) @(negedge clk);
    chk("wrD_nwr", 144'(wr_addr_q.size()), 144'(5));
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++)
      chk($sformatf("wrD_wraddr%0d", i), 144'(wr_addr_q[i]), 144'(BASE | AB'((15 + i) % 16)));
    exp_frame(5, 8'hD0, 5'd3, 15);
    fwd_start("wrD", c);
    collect_check("wrD", c);

    // Commit on the same cycle the reader pops the only FIFO entry.
    do_reset();
    send_frame(3, 8'h20, 5'd4);
    send_word(0, 5'd16, 0, 8'h28);
    send_word(0, 5'd16, 0, 8'h29);
    clear_q();
    drive(1, 1, 5'd6, 0, 8'h2A);
    forward_en = 1'b1;
    c = cyc;
    @(negedge clk);
    drive(0, 0, 5'd0, 0, 8'h00);
    forward_en = 1'b0;
    chk("cc_pend", 144'(frame_pending), 144'(1));
    exp_frame(3, 8'h20, 5'd4, 0);
    collect_check("ccA", c);
    exp_frame(3, 8'h28, 5'd6, 3);
    fwd_start("ccB", c);
    collect_check("ccB", c);
    chk("cc_done_pend", 144'(frame_pending), '0);

    // Length FIFO full at in_last drops the frame.
    do_reset();
    wr_addr_q.delete();
    for (int k = 0; k < 5; k++) send_word(1, 5'd3, 0, 8'(8'h40 + 8'(k)));
    drive(0, 0, 5'd0, 0, 8'h00);
    repeat (2) @(negedge clk);
    chk("lf_drops", 144'(drop_count), 144'(1));
    chk("lf_nwr", 144'(wr_addr_q.size()), 144'(4));
    chk("lf_pend", 144'(frame_pending), 144'(1));

    // Reset in the middle of a read burst.
    do_reset();
    send_frame(8, 8'h90, 5'd16);
    fwd_start("ri", c);
    repeat (2) @(negedge clk);
    chk("ri_issuing", 144'(ram_rd_en), 144'(1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("ri");
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
    for (int k = 0; k < 6; k++) begin
      stray = 1'(k % 2);
      @(negedge clk);
    end
    stray = 1'b0;
    repeat (4) @(negedge clk);
    chk("ri_no_fvalid", 144'(out_q.size()), '0);
    chk("ri_pend", 144'(frame_pending), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
